// File: rtl/branch_resolve.sv
// Branch resolve unit: decodes the branch condition from the comparator
// results, owns the PC register, computes the next PC and runs the
// post-redirect flush sequencer.
// Optional build feature: define BRANCH_RESOLVE_STATS_EN to add the
// branch_cnt / taken_cnt statistics outputs.
module branch_resolve #(
    parameter int                  PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC     = '0,
    parameter int                  FLUSH_CYCLES = 2,
    parameter int                  STAT_WIDTH   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                br_valid,
    input  logic                is_jal,
    input  logic                is_jalr,
    input  logic [2:0]          funct3,
    input  logic [PC_WIDTH-1:0] br_target,
    input  logic                br_eq,
    input  logic                br_lt,
    output logic                br_un,
    output logic                pc_write,
    output logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] pc_plus4,
    output logic                redirect,
    output logic                flush,
    output logic                misalign
`ifdef BRANCH_RESOLVE_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0] branch_cnt,
    output logic [STAT_WIDTH-1:0] taken_cnt
`endif
);

    // Counter is at least one bit wide so FLUSH_CYCLES=0 still elaborates.
    localparam int CNT_W = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD =
        CNT_W'((FLUSH_CYCLES > 0) ? (FLUSH_CYCLES - 1) : 0);

    typedef enum logic {
        S_RUN   = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] eff_target;
    logic                cond;
    logic                raw_take;
    logic                bad_align;
    logic                take;

    // Conditional-branch decode from funct3; 010/011 are not branches.
    function automatic logic branch_cond(input logic [2:0] f3,
                                         input logic       eq,
                                         input logic       lt);
        logic c;
        case (f3)
            3'b000:  c = eq;
            3'b001:  c = ~eq;
            3'b100:  c = lt;
            3'b101:  c = ~lt;
            3'b110:  c = lt;
            3'b111:  c = ~lt;
            default: c = 1'b0;
        endcase
        return c;
    endfunction

    assign br_un    = funct3[1];
    assign pc_write = ~stall & ~rst;
    assign pc       = pc_q;
    assign pc_plus4 = pc_q + PC_WIDTH'(4);
    assign flush    = (state_q == S_FLUSH);

    // JALR drops bit 0 of the computed target; JAL and branches use it as is.
    assign eff_target = is_jalr ? {br_target[PC_WIDTH-1:1], 1'b0} : br_target;
    assign cond       = branch_cond(funct3, br_eq, br_lt);

    // pc_write gating keeps a frozen comparator from ever producing a take.
    assign raw_take  = pc_write & (state_q == S_RUN) &
                       (is_jalr | is_jal | (br_valid & cond));
    assign bad_align = raw_take & (eff_target[1:0] != 2'b00);
    assign take      = raw_take & ~bad_align;

    // PC register: reset, redirect to target, sequential step, or hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (pc_write && take) begin
            pc_q <= eff_target;
        end else if (pc_write) begin
            pc_q <= pc_plus4;
        end
    end

    // One-cycle status pulses reported the cycle after the decision.
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect <= 1'b0;
            misalign <= 1'b0;
        end else begin
            redirect <= take;
            misalign <= bad_align;
        end
    end

    // Flush sequencer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Flush sequencer next state: count down only on cycles the PC advances.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_RUN: begin
                if (take && (FLUSH_CYCLES > 0)) begin
                    state_d = S_FLUSH;
                    cnt_d   = CNT_LOAD;
                end
            end
            S_FLUSH: begin
                if (pc_write) begin
                    if (cnt_q == '0) begin
                        state_d = S_RUN;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_RUN;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef BRANCH_RESOLVE_STATS_EN
    // A conditional branch counts only when it is not overridden by a jump.
    logic br_counted;
    assign br_counted = br_valid & ~is_jal & ~is_jalr & pc_write &
                        (state_q == S_RUN);

    // Saturating statistics counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt <= '0;
            taken_cnt  <= '0;
        end else begin
            if (br_counted && (branch_cnt != '1)) begin
                branch_cnt <= branch_cnt + STAT_WIDTH'(1);
            end
            if (br_counted && take && (taken_cnt != '1)) begin
                taken_cnt <= taken_cnt + STAT_WIDTH'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: directed scenarios followed by
// random stimulus, checked against an instruction-level PC model.
module tb_branch_resolve;

    localparam int          W     = 32;
    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam int          NFLSH = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stall = 1'b0;
    logic          br_valid = 1'b0;
    logic          is_jal = 1'b0;
    logic          is_jalr = 1'b0;
    logic [2:0]    funct3 = 3'b000;
    logic [W-1:0]  br_target = '0;
    logic          br_eq = 1'b0;
    logic          br_lt = 1'b0;
    logic          br_un;
    logic          pc_write;
    logic [W-1:0]  pc;
    logic [W-1:0]  pc_plus4;
    logic          redirect;
    logic          flush;
    logic          misalign;

    branch_resolve #(
        .PC_WIDTH(W), .RESET_PC(RPC), .FLUSH_CYCLES(NFLSH), .STAT_WIDTH(32)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .br_valid(br_valid),
        .is_jal(is_jal), .is_jalr(is_jalr), .funct3(funct3),
        .br_target(br_target), .br_eq(br_eq), .br_lt(br_lt),
        .br_un(br_un), .pc_write(pc_write), .pc(pc), .pc_plus4(pc_plus4),
        .redirect(redirect), .flush(flush), .misalign(misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic pc_write;
        logic br_un;
    } comb_exp_t;

    typedef struct {
        logic [W-1:0] pc;
        logic [W-1:0] pc_plus4;
        logic         redirect;
        logic         flush;
        logic         misalign;
    } seq_exp_t;

    comb_exp_t comb_q[$];
    seq_exp_t  seq_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Architectural model state: the PC and how many squash cycles remain.
    logic [W-1:0] m_pc = RPC;
    int           m_flush_left = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference meaning of each branch funct3 in terms of the compare results.
    function automatic bit model_cond(input logic [2:0] f3, input bit eq, input bit lt);
        case (f3)
            3'b000: return eq;          // BEQ
            3'b001: return !eq;         // BNE
            3'b100: return lt;          // BLT
            3'b101: return !lt;         // BGE
            3'b110: return lt;          // BLTU
            3'b111: return !lt;         // BGEU
            default: return 0;          // not a branch
        endcase
    endfunction

    task automatic step(input bit r, input bit s, input bit bv, input bit jl, input bit jr,
                        input logic [2:0] f3, input logic [W-1:0] tgt,
                        input bit eq, input bit lt);
        comb_exp_t    ce;
        seq_exp_t     se;
        bit           advance;
        bit           wants_jump;
        logic [W-1:0] dest;
        @(negedge clk);
        rst = r; stall = s; br_valid = bv; is_jal = jl; is_jalr = jr;
        funct3 = f3; br_target = tgt; br_eq = eq; br_lt = lt;

        advance = !r && !s;
        ce.pc_write = advance;
        ce.br_un    = (f3 == 3'b110) || (f3 == 3'b111) || (f3 == 3'b010) || (f3 == 3'b011);
        comb_q.push_back(ce);

        se.redirect = 0;
        se.misalign = 0;
        if (r) begin
            m_pc = RPC;
            m_flush_left = 0;
        end else if (advance) begin
            wants_jump = jr || jl || (bv && model_cond(f3, eq, lt));
            if (m_flush_left == 0 && wants_jump) begin
                dest = jr ? (tgt & ~32'd1) : tgt;
                if (dest % 4 != 0) begin
                    se.misalign = 1;
                    m_pc = m_pc + 4;
                end else begin
                    se.redirect = 1;
                    m_pc = dest;
                    m_flush_left = NFLSH;
                end
            end else begin
                m_pc = m_pc + 4;
                if (m_flush_left > 0) m_flush_left--;
            end
        end
        se.pc       = m_pc;
        se.pc_plus4 = m_pc + 4;
        se.flush    = (m_flush_left > 0);
        seq_q.push_back(se);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 3'b010, '0, 0, 0);
    endtask

    // Combinational outputs, checked mid-cycle after the inputs settle.
    initial begin
        comb_exp_t ce;
        forever begin
            @(negedge clk);
            #1;
            if (comb_q.size() > 0) begin
                ce = comb_q.pop_front();
                chk("pc_write", W'(pc_write), W'(ce.pc_write));
                chk("br_un", W'(br_un), W'(ce.br_un));
            end
        end
    end

    // Registered outputs, checked just after the clock edge.
    initial begin
        seq_exp_t se;
        forever begin
            @(posedge clk);
            #1;
            if (seq_q.size() > 0) begin
                se = seq_q.pop_front();
                chk("pc", pc, se.pc);
                chk("pc_plus4", pc_plus4, se.pc_plus4);
                chk("redirect", W'(redirect), W'(se.redirect));
                chk("flush", W'(flush), W'(se.flush));
                chk("misalign", W'(misalign), W'(se.misalign));
            end
        end
    end

    initial begin
        bit           bv, jl, jr, s, r;
        logic [W-1:0] t;
        int           guard;

        // Reset held two cycles, then sequential stepping from RESET_PC.
        step(1, 0, 0, 0, 0, 3'b000, '0, 0, 0);
        step(1, 0, 1, 1, 0, 3'b000, 32'h40, 1, 1);
        idle(3);

        // Reach pc=0x100 with a JAL to 0xF8 and let its flush drain.
        step(0, 0, 0, 1, 0, 3'b000, 32'hF8, 0, 0);
        idle(2);
        // BEQ taken to 0x80, then a shadow BEQ to 0x200 that must be squashed.
        step(0, 0, 1, 0, 0, 3'b000, 32'h80, 1, 0);
        step(0, 0, 1, 0, 0, 3'b000, 32'h200, 1, 0);
        idle(2);
        // BLTU not taken.
        step(0, 0, 1, 0, 0, 3'b110, 32'h300, 0, 0);
        // Stalled BNE, then released with identical inputs.
        step(0, 1, 1, 0, 0, 3'b001, 32'h40, 0, 0);
        step(0, 1, 1, 0, 0, 3'b001, 32'h40, 0, 0);
        step(0, 0, 1, 0, 0, 3'b001, 32'h40, 0, 0);
        // Stall while flushing holds the flush.
        step(0, 1, 0, 0, 0, 3'b010, '0, 0, 0);
        idle(3);
        // JALR with bit 0 set, then a JALR landing on a half-word.
        step(0, 0, 0, 0, 1, 3'b000, 32'h1001, 0, 0);
        idle(2);
        step(0, 0, 0, 0, 1, 3'b000, 32'h1006, 0, 0);
        // Reset in the middle of a flush.
        step(0, 0, 0, 1, 0, 3'b000, 32'h500, 0, 0);
        step(1, 0, 0, 0, 0, 3'b000, '0, 0, 0);
        idle(2);
        // Wrap of pc+4 at the top of the address space.
        step(0, 0, 0, 1, 0, 3'b000, 32'hFFFF_FFF8, 0, 0);
        idle(4);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            r  = ($urandom_range(63) == 0);
            s  = ($urandom_range(3) == 0);
            bv = ($urandom_range(1) == 0);
            jl = ($urandom_range(7) == 0);
            jr = ($urandom_range(7) == 0);
            t  = $urandom;
            if ($urandom_range(3) != 0) t[1:0] = 2'b00;
            step(r, s, bv, jl, jr, 3'($urandom_range(7)), t,
                 1'($urandom_range(1)), 1'($urandom_range(1)));
        end
        idle(1);

        guard = 0;
        while ((seq_q.size() > 0 || comb_q.size() > 0) && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        #3;
        if (seq_q.size() > 0 || comb_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", seq_q.size() + comb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Consumer side of the branch compare interface in the RISC-V core.
- Drives br_un and pc_write into the branch comparator and takes back br_eq/br_lt.
- Decodes the conditional-branch funct3, or the JAL/JALR flags, into a taken decision.
- Owns the PC register, computes the next PC and runs a flush FSM that squashes wrong-path instructions after a redirect.

Parameters:
- PC_WIDTH, `REG_WIDTH (32): width of the PC and target.
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- FLUSH_CYCLES, 2: cycles flush stays high after a redirect; 0 disables flushing.
- STAT_WIDTH, 32: width of the statistics counters (optional feature only).

Ports:
- clk  in  1  core clock; all state on the rising edge.
- rst  in  1  synchronous active-high reset.
- stall  in  1  hazard stall; freezes PC and the FSM.
- br_valid  in  1  conditional branch present in the resolve stage.
- is_jal  in  1  JAL present.
- is_jalr  in  1  JALR present.
- funct3  in  3  branch funct3.
- br_target  in  PC_WIDTH  target address from the ALU.
- br_eq  in  1  equal result from the comparator.
- br_lt  in  1  less-than result from the comparator.
- br_un  out  1  unsigned compare select.
- pc_write  out  1  PC update enable; also gates the comparator.
- pc  out  PC_WIDTH  current PC.
- pc_plus4  out  PC_WIDTH  pc+4, for the link register.
- redirect  out  1  one-cycle pulse: PC was loaded from the target.
- flush  out  1  squash the fetch/decode stages.
- misalign  out  1  one-cycle pulse: taken target not 4-byte aligned.

Behaviour:
- br_un = funct3[1], combinational (BLTU/BGEU).
- pc_write = ~stall & ~rst. A comparator output of 0 while pc_write=0 must never cause a taken decision.
- Condition by funct3:
  - 000 BEQ = br_eq; 001 BNE = ~br_eq.
  - 100 BLT = br_lt; 101 BGE = ~br_lt.
  - 110 BLTU = br_lt; 111 BGEU = ~br_lt.
  - 010/011: never taken.
- Effective target = br_target, with bit 0 cleared when is_jalr.
- Raw take = pc_write & state==RUN & (is_jal | is_jalr | (br_valid & cond)).
- Priority when flags overlap: is_jalr > is_jal > br_valid.
- Raw take with effective target[1:0] != 0:
  - Not taken; PC <= pc+4.
  - misalign=1 on the next cycle, state unchanged.
- Otherwise, raw take sets take=1.
- PC register, in priority order:
  - rst: PC <= RESET_PC.
  - else pc_write & take: PC <= effective target.
  - else pc_write: PC <= pc+4.
  - else hold.
  - pc+4 wraps modulo 2^PC_WIDTH.
- Redirect latency: redirect, and the new PC, are visible 1 cycle after the take cycle.
- FSM states RUN and FLUSH, with a counter of clog2(FLUSH_CYCLES+1) bits.
  - RUN to FLUSH on take when FLUSH_CYCLES>0; counter loads FLUSH_CYCLES-1. With FLUSH_CYCLES=0, stay in RUN.
  - In FLUSH, flush=1 and branches/jumps are ignored (squashed path).
  - Counter decrements only when pc_write=1; at 0 with pc_write, go to RUN.
  - stall in FLUSH holds both the counter and flush=1.
- Reset values: pc=RESET_PC, state=RUN, counter=0, redirect=0, flush=0, misalign=0.
  - pc_write=0 while rst=1.
  - Reset mid-FLUSH aborts to RUN on the next edge.

Optional Feature:
- Macro BRANCH_RESOLVE_STATS_EN.
- Defined:
  - Adds outputs branch_cnt and taken_cnt, each STAT_WIDTH.
  - branch_cnt increments on each resolved conditional branch: br_valid & pc_write & state==RUN.
  - taken_cnt increments when that branch is taken.
  - JAL/JALR are not counted.
  - Both saturate at all-ones; rst clears both.
- Undefined: the ports and counters are absent; no other change.

Test Plan:
- Reset: rst=1 for 2 cycles, RESET_PC=0x0 -> pc=0x0, flush=0, redirect=0, pc_write=0 during reset; then pc steps 0x0, 0x4, 0x8.
- BEQ taken:
  - Stimulus: pc=0x100, br_valid=1, funct3=000, br_eq=1, target=0x80.
  - Next cycle: pc=0x80, redirect=1.
  - flush=1 for exactly 2 cycles (pc 0x80, 0x84), then 0.
- BLTU not taken: funct3=110, br_lt=0 -> br_un=1; pc 0x100 -> 0x104, redirect=0, flush=0.
- Branch in shadow: second br_valid with BEQ, br_eq=1, target=0x200, during the first FLUSH cycle -> ignored; pc continues 0x84, 0x88.
- Stall:
  - Stimulus: stall=1 with BNE, br_eq=0, target=0x40.
  - During stall: pc_write=0, pc holds, no redirect.
  - Stall released with the same inputs -> pc=0x40 next cycle.
- JALR alignment:
  - target=0x1001 -> pc=0x1000, redirect=1.
  - target=0x1006 -> misalign=1, pc=prev+4, flush=0.
  - With BRANCH_RESOLVE_STATS_EN defined: counters do not change on either JALR.
